uart_tx_sequencer: RTL and testbench
====================================

# uart_tx_sequencer

Message-level scheduler in front of the byte-wide UART transmitter. Two requesters (A, B) each offer a message of up to `MSG_BYTES` bytes. The block arbitrates round-robin, latches the winning message, and feeds it to the transmitter one byte at a time using the transmitter's enable/sent handshake. It reports acceptance and completion back to the winning requester.

## Interface
- `MSG_BYTES`, default 14: maximum message length in bytes. Legal range is 1..15.
- `GAP_CYCLES`, default 16: idle clock cycles inserted between consecutive bytes. Legal range is 0..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `req_a` / `req_b` in 1: level request from requester A / B.
- `msg_a` / `msg_b` in 8*MSG_BYTES: message payload; byte k is `msg[8k+7:8k]`, and byte 0 is sent first.
- `len_a` / `len_b` in 4: number of bytes to send. Values above `MSG_BYTES` are clamped to `MSG_BYTES`.
- `ack_a` / `ack_b` out 1: one-cycle pulse; the message was latched and the requester may change `msg`, `len` and `req`.
- `done_a` / `done_b` out 1: one-cycle pulse; the last byte has been fully sent.
- `tx_data` out 8: byte presented to the transmitter.
- `tx_ena` out 1: transmitter enable; the transmitter acts on its rising edge.
- `tx_sent` in 1: transmitter status; low while a byte is in flight, high when finished.
- `busy` out 1: high in every state except IDLE.
- `owner` out 1: 0 = A, 1 = B; identifies the requester currently or last served.

## Operation
- States:
  - **IDLE**: wait for a request.
  - **LOAD**: latch the winning message.
  - **START**: assert `tx_ena` until the transmitter starts.
  - **WAIT_SENT**: wait for the byte to complete.
  - **GAP**: count `GAP_CYCLES` between bytes.
  - **DONE**: signal completion.
- IDLE → LOAD when `req_a` or `req_b` is high.
  - Only one request high: that requester wins.
  - Both high: the requester that is not `owner` wins.
  - `owner` resets to 1, so A wins the first contest after reset.
- LOAD (1 cycle):
  - Latch `msg`/`len` of the winner; `owner` ← winner.
  - Pulse `ack_<winner>`; clear byte index and checksum.
  - Effective length 0 → go to DONE with no bytes sent.
  - Otherwise go to START.
- START:
  - `tx_data` = current byte; `tx_ena` = 1.
  - Stay until `tx_sent` is sampled 0, then go to WAIT_SENT with `tx_ena` = 0.
- WAIT_SENT: on `tx_sent` sampled 1, increment the index.
  - Bytes remain: go to GAP.
  - No bytes remain: go to DONE.
- GAP: go to START after exactly `GAP_CYCLES` cycles in GAP. `GAP_CYCLES` = 0 goes directly from WAIT_SENT to START.
- DONE (1 cycle): pulse `done_<owner>`, then go to IDLE.
- Requests are level-sensitive. A `req` still high in IDLE after DONE is treated as a new message and is subject to round-robin.
- Requests arriving while `busy` are ignored; they are not queued beyond the level itself.
- Byte index width is 4 bits. No wrap is possible because the index is bounded by the clamped length.

## Timing
- Reset values:
  - Outputs: `tx_ena`=0, `tx_data`=8'h00, `ack_*`=0, `done_*`=0, `busy`=0, `owner`=1.
  - State: IDLE.
- Latency:
  - `req` high in cycle n (IDLE) → `ack` high in cycle n+1.
  - `tx_ena` rises in cycle n+2.
  - `tx_data` is stable from that cycle until the byte's `tx_sent` rises.
- `tx_ena` is held high for at least 1 cycle, until `tx_sent` = 0 is observed.
- Byte-to-byte spacing: the next `tx_ena` rises exactly `GAP_CYCLES` + 1 cycles after `tx_sent` is observed high.
- `done` is asserted 1 cycle after the final `tx_sent` rise. For length 0, `done` is asserted 1 cycle after `ack`.
- `reset` mid-message:
  - All outputs return to reset values immediately (asynchronous).
  - The message is discarded; no `done` is pulsed.
  - The first post-reset transfer restarts at byte 0.
- The `ack` and `done` pulses never overlap.

## Configuration
- Macro: `UART_TX_SEQ_CHECKSUM_EN`.
- Defined:
  - A running XOR of all bytes sent is kept.
  - After the last payload byte, one extra byte equal to that XOR is sent, using the same GAP and handshake.
  - `done` follows the checksum byte.
  - Length 0 sends only the checksum byte, 8'h00.
- Undefined:
  - No checksum logic; exactly `len` bytes are sent.

## Test plan
- A only, `len_a`=3, `msg_a` low bytes 8'h41/8'h42/8'h43, `GAP_CYCLES`=16, behavioral transmitter model:
  - `ack_a` 1 cycle after `req_a`.
  - `tx_data` sequence is 41, 42, 43 with 17-cycle spacing.
  - `done_a` once; `owner`=0.
- `req_a` and `req_b` both high in the same cycle after reset:
  - A is served first; B is served next.
  - A third simultaneous contest goes to A again.
- `len_b`=0:
  - `ack_b`, then `done_b` the next cycle.
  - `tx_ena` never rises; checksum build sends one 8'h00.
- `len_a`=15 with `MSG_BYTES`=14: exactly 14 bytes sent.
- `reset` pulsed during the 2nd byte of a 5-byte message:
  - All outputs at reset values the same cycle; no `done`.
  - The next request sends from byte 0.
- Checksum build, message 8'h12, 8'h34: bytes sent are 12, 34, 26; `done` after the third byte.

Source files
------------

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer
// -----------------
// Message-level scheduler placed in front of a byte-wide UART transmitter.
// Two requesters (A and B) each offer a message of up to MSG_BYTES bytes.
// A round-robin arbiter picks one message and latches it. The message is
// then sent to the transmitter one byte at a time, with GAP_CYCLES idle
// cycles between bytes.
//
// Optional feature: define UART_TX_SEQ_CHECKSUM_EN to append a trailing
// byte. That byte is the XOR of all payload bytes. A zero-length message
// then sends only 8'h00.
//
// Parameters
//   MSG_BYTES   maximum message length, 1..15
//   GAP_CYCLES  idle cycles between bytes, 0..255
//
// Ports
//   clk, reset        clock; asynchronous active-high reset
//   req_a / req_b     level requests
//   msg_a / msg_b     payloads; byte k is msg[8k+7:8k], byte 0 goes first
//   len_a / len_b     byte counts; values above MSG_BYTES are clamped
//   ack_a / ack_b     1-cycle pulse: the message was latched
//   done_a / done_b   1-cycle pulse: the last byte has completed
//   tx_data, tx_ena   byte and enable driven to the transmitter
//   tx_sent           transmitter status: low while a byte is in flight
//   busy              high in every state except IDLE
//   owner             requester currently or last served (0 = A, 1 = B)
//
// Transmitter handshake: tx_ena is held high (with tx_data stable) until
// tx_sent is sampled low. The byte is then in flight, and it is complete
// when tx_sent is sampled high again. tx_data stays stable until that
// completion has been observed.
module uart_tx_sequencer #(
   parameter int MSG_BYTES  = 14,
   parameter int GAP_CYCLES = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_a,
   input  logic                   req_b,
   input  logic [8*MSG_BYTES-1:0] msg_a,
   input  logic [8*MSG_BYTES-1:0] msg_b,
   input  logic [3:0]             len_a,
   input  logic [3:0]             len_b,
   output logic                   ack_a,
   output logic                   ack_b,
   output logic                   done_a,
   output logic                   done_b,
   output logic [7:0]             tx_data,
   output logic                   tx_ena,
   input  logic                   tx_sent,
   output logic                   busy,
   output logic                   owner
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_LOAD      = 3'd1;
   localparam logic [2:0] S_START     = 3'd2;
   localparam logic [2:0] S_WAIT_SENT = 3'd3;
   localparam logic [2:0] S_GAP       = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam logic [3:0] MAX_LEN  = 4'(MSG_BYTES);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   logic [2:0]             state_q;
   logic                   owner_q;
   logic [8*MSG_BYTES-1:0] msg_q;
   logic [3:0]             len_q;
   logic [3:0]             idx_q;
   logic [7:0]             gap_q;

   logic                   grant_b;
   logic [3:0]             win_len_raw;
   logic [3:0]             win_len;
   logic [7:0]             payload_byte;
   logic                   last_byte;
   logic                   zero_len_done;

   // On a tie, the requester that was not served last wins.
   assign grant_b     = req_b & (~req_a | ~owner_q);
   assign win_len_raw = grant_b ? len_b : len_a;
   assign win_len     = (win_len_raw > MAX_LEN) ? MAX_LEN : win_len_raw;

   // Byte selector written as a loop, so an index past the message gives 0
   // instead of an out-of-range part select.
   always_comb begin
      payload_byte = 8'h00;
      for (int k = 0; k < MSG_BYTES; k++) begin
         if (idx_q == 4'(k)) payload_byte = msg_q[8*k +: 8];
      end
   end

`ifdef UART_TX_SEQ_CHECKSUM_EN
   logic [7:0] chk_q;

   // Index == len marks the trailing checksum byte.
   assign tx_data       = (idx_q == len_q) ? chk_q : payload_byte;
   assign last_byte     = (idx_q == len_q);
   assign zero_len_done = 1'b0;
`else
   assign tx_data       = payload_byte;
   assign last_byte     = ((idx_q + 4'd1) == len_q);
   assign zero_len_done = (len_q == 4'd0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         owner_q <= 1'b1;
         msg_q   <= '0;
         len_q   <= 4'd0;
         idx_q   <= 4'd0;
         gap_q   <= 8'd0;
`ifdef UART_TX_SEQ_CHECKSUM_EN
         chk_q   <= 8'h00;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               // The winner's message is captured on the edge that enters
               // LOAD, so ack in LOAD already reflects latched data.
               if (req_a | req_b) begin
                  owner_q <= grant_b;
                  msg_q   <= grant_b ? msg_b : msg_a;
                  len_q   <= win_len;
                  idx_q   <= 4'd0;
`ifdef UART_TX_SEQ_CHECKSUM_EN
                  chk_q   <= 8'h00;
`endif
                  state_q <= S_LOAD;
               end
            end
            S_LOAD: begin
               state_q <= zero_len_done ? S_DONE : S_START;
            end
            S_START: begin
               if (!tx_sent) state_q <= S_WAIT_SENT;
            end
            S_WAIT_SENT: begin
               if (tx_sent) begin
                  idx_q <= idx_q + 4'd1;
`ifdef UART_TX_SEQ_CHECKSUM_EN
                  if (!last_byte) chk_q <= chk_q ^ payload_byte;
`endif
                  gap_q <= 8'd0;
                  if (last_byte)            state_q <= S_DONE;
                  else if (GAP_CYCLES == 0) state_q <= S_START;
                  else                      state_q <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_q == GAP_LAST) state_q <= S_START;
               else                   gap_q   <= gap_q + 8'd1;
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // All outputs are decoded from registers, so an asynchronous reset
   // returns them to their idle values immediately.
   assign busy   = (state_q != S_IDLE);
   assign tx_ena = (state_q == S_START);
   assign ack_a  = (state_q == S_LOAD) & ~owner_q;
   assign ack_b  = (state_q == S_LOAD) &  owner_q;
   assign done_a = (state_q == S_DONE) & ~owner_q;
   assign done_b = (state_q == S_DONE) &  owner_q;
   assign owner  = owner_q;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Testbench for uart_tx_sequencer.
//
// Structure:
//   - a behavioral transmitter model;
//   - a monitor that compares every ack, byte and done against an
//     expected-event queue, and also checks spacing and timing;
//   - directed driver tasks that push the hand-computed events.
//
// Event encoding: {kind[1:0], data[7:0]}
//   kind 0 = ack,  data = side
//   kind 1 = byte, data = byte value
//   kind 2 = done, data = side
module tb_uart_tx_sequencer;

   localparam int MSG_BYTES  = 14;
   localparam int GAP_CYCLES = 16;
   localparam int W          = 10;
   localparam int FLIGHT     = 3;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   req_a = 1'b0;
   logic                   req_b = 1'b0;
   logic [8*MSG_BYTES-1:0] msg_a = '0;
   logic [8*MSG_BYTES-1:0] msg_b = '0;
   logic [3:0]             len_a = 4'd0;
   logic [3:0]             len_b = 4'd0;
   logic                   ack_a, ack_b, done_a, done_b;
   logic [7:0]             tx_data;
   logic                   tx_ena;
   logic                   tx_sent = 1'b1;
   logic                   busy, owner;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic [W-1:0] exp_q[$];

   int         hi_cyc = 0;
   int         ack_cyc = 0;
   int         nbytes = 0;
   int         flight = 0;
   int         ack_cnt = 0;
   int         done_cnt = 0;
   logic       model_ena_prev = 1'b0;
   logic       mon_ena_prev = 1'b0;
   logic       sent_prev = 1'b1;
   logic [7:0] last_byte = 8'h00;

   uart_tx_sequencer #(.MSG_BYTES(MSG_BYTES), .GAP_CYCLES(GAP_CYCLES)) dut (
      .clk(clk), .reset(reset),
      .req_a(req_a), .req_b(req_b),
      .msg_a(msg_a), .msg_b(msg_b),
      .len_a(len_a), .len_b(len_b),
      .ack_a(ack_a), .ack_b(ack_b),
      .done_a(done_a), .done_b(done_b),
      .tx_data(tx_data), .tx_ena(tx_ena), .tx_sent(tx_sent),
      .busy(busy), .owner(owner)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc = cyc + 1;

   // ---------------- checkers ----------------
   task automatic check(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic sb_check(input logic [W-1:0] act);
      logic [W-1:0] e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL sb_event: got %h, expected none (queue empty) at cycle %0d",
                  act, cyc);
      end else begin
         e = exp_q.pop_front();
         if (act !== e) begin
            fails++;
            $display("FAIL sb_event: got %h, expected %h at cycle %0d", act, e, cyc);
         end
      end
   endtask

   // ---------------- transmitter model ----------------
   // On a rising tx_ena: go busy, then report done FLIGHT cycles later.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         tx_sent        = 1'b1;
         flight         = 0;
         model_ena_prev = 1'b0;
      end else begin
         if (tx_ena && !model_ena_prev) begin
            tx_sent = 1'b0;
            flight  = FLIGHT;
         end else if (flight > 0) begin
            flight--;
            if (flight == 0) begin
               tx_sent = 1'b1;
               hi_cyc  = cyc;
            end
         end
         model_ena_prev = tx_ena;
      end
   end

   // ---------------- monitor ----------------
   always @(posedge clk) begin
      #2;
      if (reset) begin
         mon_ena_prev = 1'b0;
         sent_prev    = 1'b1;
      end else begin
         if (ack_a | ack_b | done_a | done_b)
            check("ack_done_overlap", int'((ack_a | ack_b) & (done_a | done_b)), 0);
         if (ack_a | ack_b) begin
            check("ack_onehot", int'(ack_a & ack_b), 0);
            sb_check({2'd0, 7'd0, ack_b});
            ack_cyc = cyc;
            nbytes  = 0;
            ack_cnt++;
         end
         if (tx_ena && !mon_ena_prev) begin
            sb_check({2'd1, tx_data});
            if (nbytes > 0) check("byte_spacing", cyc - hi_cyc, GAP_CYCLES + 1);
            last_byte = tx_data;
            nbytes++;
         end
         if (tx_sent && !sent_prev) check("tx_data_stable", int'(tx_data), int'(last_byte));
         if (done_a | done_b) begin
            sb_check({2'd2, 7'd0, done_b});
            check("done_timing", cyc, (nbytes > 0) ? hi_cyc + 1 : ack_cyc + 1);
            done_cnt++;
         end
         mon_ena_prev = tx_ena;
         sent_prev    = tx_sent;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_msg(input logic side, input logic [8*MSG_BYTES-1:0] m,
                           input logic [3:0] len);
      int n;
      logic [7:0] b;
      logic [7:0] x;
      n = (int'(len) > MSG_BYTES) ? MSG_BYTES : int'(len);
      x = 8'h00;
      exp_q.push_back({2'd0, 7'd0, side});
      for (int i = 0; i < n; i++) begin
         b = m[8*i +: 8];
         x = x ^ b;
         exp_q.push_back({2'd1, b});
      end
`ifdef UART_TX_SEQ_CHECKSUM_EN
      exp_q.push_back({2'd1, x});
`endif
      exp_q.push_back({2'd2, 7'd0, side});
   endtask

   task automatic wait_done(input int target, input int budget, input string name);
      int i;
      i = 0;
      while (done_cnt < target && i < budget) begin
         @(posedge clk); #3;
         i++;
      end
      check(name, int'(done_cnt >= target), 1);
   endtask

   task automatic single(input logic side, input logic [8*MSG_BYTES-1:0] m,
                         input logic [3:0] len);
      int start, a0, d0, i;
      @(posedge clk); #3;
      if (side) begin msg_b = m; len_b = len; end
      else      begin msg_a = m; len_a = len; end
      push_msg(side, m, len);
      start = cyc;
      a0 = ack_cnt;
      d0 = done_cnt;
      if (side) req_b = 1'b1; else req_a = 1'b1;
      i = 0;
      while (ack_cnt == a0 && i < 10) begin @(posedge clk); #3; i++; end
      check("ack_latency", ack_cyc, start + 1);
      check("busy_after_ack", int'(busy), 1);
      req_a = 1'b0;
      req_b = 1'b0;
      wait_done(d0 + 1, 2000, "done_seen");
      check("owner_after_msg", int'(owner), int'(side));
      check("queue_drained", exp_q.size(), 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [8*MSG_BYTES-1:0] m;
      int a0, d0, i;

      // Reset values
      repeat (2) @(posedge clk);
      #3;
      check("rst_tx_ena",  int'(tx_ena), 0);
      check("rst_tx_data", int'(tx_data), 0);
      check("rst_ack",     int'(ack_a | ack_b), 0);
      check("rst_done",    int'(done_a | done_b), 0);
      check("rst_busy",    int'(busy), 0);
      check("rst_owner",   int'(owner), 1);
      reset = 1'b0;

      // Contest: A, then B, then A again
      @(posedge clk); #3;
      msg_a = '0; msg_a[7:0] = 8'hA1; len_a = 4'd1;
      msg_b = '0; msg_b[7:0] = 8'hB1; len_b = 4'd1;
      push_msg(1'b0, msg_a, 4'd1);
      push_msg(1'b1, msg_b, 4'd1);
      push_msg(1'b0, msg_a, 4'd1);
      a0 = ack_cnt;
      d0 = done_cnt;
      req_a = 1'b1;
      req_b = 1'b1;
      i = 0;
      while (ack_cnt < a0 + 3 && i < 1000) begin @(posedge clk); #3; i++; end
      req_a = 1'b0;
      req_b = 1'b0;
      check("contest_acks", ack_cnt - a0, 3);
      wait_done(d0 + 3, 1000, "contest_done");
      check("contest_owner", int'(owner), 0);
      check("contest_queue", exp_q.size(), 0);

      // A only: 41, 42, 43
      m = '0; m[7:0] = 8'h41; m[15:8] = 8'h42; m[23:16] = 8'h43;
      single(1'b0, m, 4'd3);

      // B with length 0
      m = '0; m[7:0] = 8'h99;
      single(1'b1, m, 4'd0);

      // Length 15 is clamped to 14
      m = '0;
      for (int k = 0; k < MSG_BYTES; k++) m[8*k +: 8] = 8'(8'h60 + k);
      single(1'b0, m, 4'd15);

      // Reset during the 2nd byte of a 5-byte message
      @(posedge clk); #3;
      m = '0;
      for (int k = 0; k < 5; k++) m[8*k +: 8] = 8'(8'hC0 + k);
      msg_a = m; len_a = 4'd5;
      push_msg(1'b0, m, 4'd5);
      a0 = ack_cnt;
      req_a = 1'b1;
      i = 0;
      while (ack_cnt == a0 && i < 10) begin @(posedge clk); #3; i++; end
      req_a = 1'b0;
      i = 0;
      while (nbytes < 2 && i < 200) begin @(posedge clk); #3; i++; end
      check("mid_second_byte", nbytes, 2);
      @(posedge clk); #3;
      reset = 1'b1;
      #1;
      check("mid_rst_tx_ena",  int'(tx_ena), 0);
      check("mid_rst_tx_data", int'(tx_data), 0);
      check("mid_rst_ack",     int'(ack_a | ack_b), 0);
      check("mid_rst_done",    int'(done_a | done_b), 0);
      check("mid_rst_busy",    int'(busy), 0);
      check("mid_rst_owner",   int'(owner), 1);
      exp_q.delete();
      d0 = done_cnt;
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b0;
      repeat (40) @(posedge clk);
      #3;
      check("no_done_after_reset", done_cnt, d0);
      check("idle_after_reset", int'(busy), 0);
      m = '0;
      for (int k = 0; k < 5; k++) m[8*k +: 8] = 8'(8'h51 + k);
      single(1'b0, m, 4'd5);

      // Message 12, 34 (the checksum build appends 26)
      m = '0; m[7:0] = 8'h12; m[15:8] = 8'h34;
      single(1'b1, m, 4'd2);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
